// File: rtl/ext_int_gen_pkg.sv
// Shared peripheral constants: address map, external interrupt generator
// register offsets, CTRL bit positions and state encoding.
package ext_int_gen_pkg;

  localparam logic [31:0] TIMER0_BASE_ADDR = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE_ADDR = 32'h0000_7F10;
  localparam logic [31:0] EIG_BASE_ADDR    = 32'h0000_7F20;

  localparam logic [1:0] EIG_OFF_ACK    = 2'd0;
  localparam logic [1:0] EIG_OFF_PERIOD = 2'd1;
  localparam logic [1:0] EIG_OFF_CTRL   = 2'd2;
  localparam logic [1:0] EIG_OFF_COUNT  = 2'd3;

  localparam int EIG_CTRL_EN       = 0;
  localparam int EIG_CTRL_PERIODIC = 1;
  localparam int EIG_CTRL_OVR_LSB  = 8;

  typedef logic [1:0] eig_state_t;

  localparam eig_state_t EIG_ST_IDLE  = 2'd0;
  localparam eig_state_t EIG_ST_COUNT = 2'd1;
  localparam eig_state_t EIG_ST_PEND  = 2'd2;

endpackage

// File: rtl/ext_int_gen.sv
// Memory-mapped periodic / one-shot external interrupt generator with
// acknowledge, saturating overrun counter and combinational register reads.
module ext_int_gen
  import ext_int_gen_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = EIG_BASE_ADDR,
  parameter int unsigned OVR_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        interrupt
);

  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

  eig_state_t       state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      count_q, count_d;
  logic             en_q, en_d;
  logic             periodic_q, periodic_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             interrupt_q, interrupt_d;

  logic        hit_s, wr_s, ack_s, period_wr_s, ctrl_wr_s;
  logic [1:0]  offset_s;
  logic [31:0] period_merge_s;
  logic [31:0] ctrl_rd_s;
  logic        en_wr_s, periodic_wr_s, ovr_clr_s;
  logic        run_s, expiry_s, load_s, disable_s;
  logic        unused_s;

  assign hit_s       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset_s    = addr[3:2];
  assign wr_s        = hit_s && (byteen != 4'b0000);
  assign ack_s       = wr_s && (offset_s == EIG_OFF_ACK);
  assign period_wr_s = wr_s && (offset_s == EIG_OFF_PERIOD);
  assign ctrl_wr_s   = wr_s && (offset_s == EIG_OFF_CTRL);
  assign unused_s    = ^addr[1:0];

  assign en_wr_s       = byteen[0] ? wdata[EIG_CTRL_EN] : en_q;
  assign periodic_wr_s = byteen[0] ? wdata[EIG_CTRL_PERIODIC] : periodic_q;
  assign ovr_clr_s     = ctrl_wr_s && byteen[1] && wdata[EIG_CTRL_OVR_LSB];
  assign disable_s     = ctrl_wr_s && !en_wr_s;

  // Counting stops at zero so a re-enable with PERIOD=0 can never wrap COUNT.
  assign run_s    = (state_q != EIG_ST_IDLE) && en_q && (count_q != 32'd0);
  assign expiry_s = run_s && (count_q == 32'd1);
  assign load_s   = ctrl_wr_s && en_wr_s && (period_q != 32'd0) &&
                    ((state_q == EIG_ST_IDLE) || !en_q);

  assign ctrl_rd_s = (32'(ovr_q) << EIG_CTRL_OVR_LSB) | {30'd0, periodic_q, en_q};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      period_merge_s[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : period_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_wr_s ? period_merge_s : period_q;
    en_d       = ctrl_wr_s ? en_wr_s : en_q;
    periodic_d = ctrl_wr_s ? periodic_wr_s : periodic_q;
    ovr_d      = ovr_q;
    if (disable_s) begin
      state_d = EIG_ST_IDLE;
    end else begin
      if (load_s) begin
        count_d = period_q;
      end else if (run_s) begin
        count_d = expiry_s ? (periodic_q ? period_q : 32'd0) : (count_q - 32'd1);
      end else begin
        count_d = count_q;
      end
      if (expiry_s && !periodic_q) begin
        en_d = 1'b0;
      end else begin
        en_d = ctrl_wr_s ? en_wr_s : en_q;
      end
      case (state_q)
        EIG_ST_IDLE:  state_d = load_s ? EIG_ST_COUNT : EIG_ST_IDLE;
        EIG_ST_COUNT: state_d = expiry_s ? EIG_ST_PEND : EIG_ST_COUNT;
        EIG_ST_PEND: begin
          if (ack_s && !expiry_s) begin
            state_d = en_q ? EIG_ST_COUNT : EIG_ST_IDLE;
          end else begin
            state_d = EIG_ST_PEND;
          end
          // An unacknowledged expiry while already pending is an overrun.
          if (expiry_s && !ack_s && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + OVR_ONE;
          end else begin
            ovr_d = ovr_q;
          end
        end
        default: state_d = EIG_ST_IDLE;
      endcase
    end
    if (ovr_clr_s) begin
      ovr_d = '0;
    end else begin
      ovr_d = ovr_d;
    end
  end

  assign interrupt_d = (state_d == EIG_ST_PEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EIG_ST_IDLE;
      period_q    <= 32'd0;
      count_q     <= 32'd0;
      en_q        <= 1'b0;
      periodic_q  <= 1'b0;
      ovr_q       <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      count_q     <= count_d;
      en_q        <= en_d;
      periodic_q  <= periodic_d;
      ovr_q       <= ovr_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;

  always_comb begin
    rdata = 32'd0;
    if (hit_s) begin
      case (offset_s)
        EIG_OFF_PERIOD: rdata = period_q;
        EIG_OFF_CTRL:   rdata = ctrl_rd_s;
        EIG_OFF_COUNT:  rdata = count_q;
        default:        rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: doc/ext_int_gen.md
EXT_INT_GEN -- requirements
Module: ext_int_gen

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F20, word-aligned base of the 16-byte register window.
REQ-002 SHALL have parameter OVR_W, default 8, width of the saturating overrun counter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port addr, input, 32, byte address from the CPU data-side interrupt bus (m_int_addr).
REQ-006 SHALL have port byteen, input, 4, byte write enables (m_int_byteen); nonzero means write.
REQ-007 SHALL have port wdata, input, 32, write data, byte lanes aligned to byteen.
REQ-008 SHALL have port rdata, output, 32, combinational read data for addr.
REQ-009 SHALL have port interrupt, output, 1, registered external interrupt request into HWInt[2].

Function
REQ-010 SHALL decode hit = (addr[31:4] == BASE_ADDR[31:4]); addr[1:0] is ignored; offset = addr[3:2].
REQ-011 SHALL implement registers: off0 ACK (write-only, reads 0); off1 PERIOD (32-bit RW); off2 CTRL (bit0 EN, bit1 PERIODIC, bits[8+OVR_W-1:8] OVR read-only, others read 0); off3 COUNT (read-only).
REQ-012 SHALL merge writes to PERIOD and CTRL per byte lane; lanes with byteen[i]=0 keep their old value.
REQ-013 SHALL treat any hit write to ACK (any nonzero byteen, any data) as an acknowledge.
REQ-014 SHALL drive rdata = 0 when there is no hit.
REQ-015 SHALL run state machine IDLE, COUNT, PEND; interrupt = 1 exactly in PEND.
REQ-016 IDLE -> COUNT on the edge where EN goes 1 with PERIOD != 0; COUNT <= PERIOD on that edge.
REQ-017 SHALL treat EN=1 with PERIOD=0 as no-op: remain IDLE; COUNT holds.
REQ-018 In COUNT/PEND with EN=1, COUNT SHALL decrement by 1 per cycle; expiry = (COUNT == 1) at the edge.
REQ-019 SHALL enter PEND on expiry edge: interrupt rises PERIOD cycles after the enable edge.
REQ-020 On expiry with PERIODIC=1 SHALL reload COUNT <= PERIOD; with PERIODIC=0 SHALL clear EN and hold COUNT at 0.
REQ-021 In PEND, ack without simultaneous expiry -> COUNT if EN=1 else IDLE; interrupt falls the edge after the ack write.
REQ-022 In PEND, expiry without ack SHALL stay PEND and increment OVR, saturating at all-ones.
REQ-023 In PEND, ack and expiry on the same edge SHALL stay PEND (new event), OVR unchanged.
REQ-024 Ack in IDLE or COUNT SHALL have no effect.
REQ-025 Write of EN=0 in any state SHALL go IDLE on that edge and drop interrupt; COUNT holds its value.
REQ-026 PERIOD write while counting SHALL affect only the next reload/enable, not the running COUNT.
REQ-027 Any CTRL write SHALL clear OVR if wdata[8] is 1 in an enabled lane (write-1-to-clear).

Reset
REQ-028 On reset SHALL asynchronously set state IDLE, interrupt 0, PERIOD 0, CTRL 0 (EN 0, PERIODIC 0, OVR 0), COUNT 0.
REQ-029 Reset asserted mid-count or in PEND SHALL drop interrupt within the same cycle without waiting for a clock edge.
REQ-030 After reset release the block SHALL stay IDLE until software writes EN=1.

Structure
REQ-031 Register offsets, CTRL bit positions, default BASE_ADDR and the state encoding SHALL live in the shared header package alongside other peripheral address constants.
REQ-032 SHALL be a single module; no sub-module is warranted.
REQ-033 SHALL be instantiated in mips on the m_int_addr/m_int_byteen/m_data_wdata path, output feeding HWInt[2].

Verification
REQ-034 PERIOD=5, CTRL=3 write at edge t -> interrupt high from edge t+5; COUNT reads 5,4,3,2,1 on edges t..t+4.
REQ-035 PERIODIC=0, PERIOD=3, ACK at edge t+4 -> interrupt high t+3..t+4, low after t+4; EN reads 0; state IDLE.
REQ-036 PERIODIC=1, PERIOD=4, no ACK for 12 cycles -> OVR reads 2; CTRL write with wdata[8]=1 -> OVR 0.
REQ-037 PERIOD=4 periodic, ACK exactly on second expiry edge -> interrupt stays high, OVR 0.
REQ-038 Write PERIOD with byteen=4'b0001, wdata=32'hAABBCC07 over PERIOD=32'h100 -> PERIOD reads 32'h107.
REQ-039 Reset pulsed between edges while in PEND -> interrupt 0 immediately; all registers read 0.
